// File: rtl/light_serializer_if.sv
// Bus between the LED flasher and the serializer: bar pattern and send request in,
// busy plus the three-wire shift-register link out.
interface light_serializer_if;
  logic [15:0] light;
  logic        send;
  logic        busy;
  logic        sclk;
  logic        sdata;
  logic        latch;

  modport master (output light, send, input busy, sclk, sdata, latch);
  modport slave  (input light, send, output busy, sclk, sdata, latch);
endinterface

// File: rtl/light_serializer.sv
// Shifts a 16-bit LED bar pattern MSB first into an external shift register, then latches it.
// Optional feature macro: LIGHT_SERIALIZER_CHANGE_DETECT_EN (auto-send on light change).
module light_serializer #(
  parameter int HALF = 2
) (
  input  logic             clk,
  input  logic             reset,
  light_serializer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t      state, state_nxt;
  logic [15:0] shreg;
  logic [7:0]  div;
  logic [3:0]  bit_cnt;
  logic        phase;
  logic        start;
  logic        div_end;

  assign div_end = (div == 8'(HALF - 1));

`ifdef LIGHT_SERIALIZER_CHANGE_DETECT_EN
  logic [15:0] last_sent;
  logic        pending;

  assign start = bus.send || pending || (bus.light != last_sent);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_sent <= '0;
      pending   <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        last_sent <= bus.light;
        pending   <= 1'b0;
      end
    end else if (bus.light != last_sent) begin
      pending <= 1'b1;
    end
  end
`else
  assign start = bus.send;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (div_end && phase && bit_cnt == 4'd15) state_nxt = LATCH;
      LATCH:   if (div_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // phase is the sclk level; a bit advances only at the end of its high phase
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      div     <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          div     <= '0;
          bit_cnt <= '0;
          phase   <= 1'b0;
          if (start) shreg <= bus.light;
        end
        SHIFT: begin
          if (div_end) begin
            div   <= '0;
            phase <= ~phase;
            if (phase) begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        LATCH: div <= div_end ? 8'd0 : div + 8'd1;
        default: div <= '0;
      endcase
    end
  end

  assign bus.busy  = (state != IDLE);
  assign bus.sclk  = (state == SHIFT) && phase;
  assign bus.sdata = (state == SHIFT) && shreg[15];
  assign bus.latch = (state == LATCH);

endmodule
